// File: rtl/wb_openram_wrapper.sv
// Dual-port Wishbone slave front-end for the sky130 OpenRAM 1rw1r 32x256 macro.
// One Wishbone port owns the RAM RW port; the other is routed to the read-only port.
module wb_openram_wrapper #(
    parameter int ADR_W     = 10,
    parameter int RAM_ADR_W = 8,
    parameter int DAT_W     = 32
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   writable_port_req,

    input  logic                   wbs_a_stb_i,
    input  logic                   wbs_a_cyc_i,
    input  logic                   wbs_a_we_i,
    input  logic [DAT_W/8-1:0]     wbs_a_sel_i,
    input  logic [DAT_W-1:0]       wbs_a_dat_i,
    input  logic [ADR_W-1:0]       wbs_a_adr_i,
    output logic                   wbs_a_ack_o,
    output logic [DAT_W-1:0]       wbs_a_dat_o,

    input  logic                   wbs_b_stb_i,
    input  logic                   wbs_b_cyc_i,
    input  logic                   wbs_b_we_i,
    input  logic [DAT_W/8-1:0]     wbs_b_sel_i,
    input  logic [DAT_W-1:0]       wbs_b_dat_i,
    input  logic [ADR_W-1:0]       wbs_b_adr_i,
    output logic                   wbs_b_ack_o,
    output logic [DAT_W-1:0]       wbs_b_dat_o,

    output logic                   ram_clk0,
    output logic                   ram_csb0,
    output logic                   ram_web0,
    output logic [DAT_W/8-1:0]     ram_wmask0,
    output logic [RAM_ADR_W-1:0]   ram_addr0,
    output logic [DAT_W-1:0]       ram_din0,
    input  logic [DAT_W-1:0]       ram_dout0,

    output logic                   ram_clk1,
    output logic                   ram_csb1,
    output logic [RAM_ADR_W-1:0]   ram_addr1,
    input  logic [DAT_W-1:0]       ram_dout1
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    owner_e owner_q, owner_d;
    logic   ack_a_q, ack_a_d;
    logic   ack_b_q, ack_b_d;
    logic   req_a, req_b, busy;

    logic                 rw_req, rw_we, ro_req, ro_we;
    logic [DAT_W/8-1:0]   rw_sel;
    logic [DAT_W-1:0]     rw_dat;
    logic [ADR_W-1:0]     rw_adr, ro_adr;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

    assign req_a = wbs_a_stb_i & wbs_a_cyc_i & ~ack_a_q;
    assign req_b = wbs_b_stb_i & wbs_b_cyc_i & ~ack_b_q;

    // Ownership may only change when no request or ack is outstanding on either port.
    assign busy = (wbs_a_stb_i & wbs_a_cyc_i) | (wbs_b_stb_i & wbs_b_cyc_i) | ack_a_q | ack_b_q;

    always_comb begin
        owner_d = owner_q;
        if (!busy) begin
            owner_d = writable_port_req ? OWN_B : OWN_A;
        end
        ack_a_d = req_a;
        ack_b_d = req_b;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            owner_q <= OWN_A;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
        end
    end

    always_comb begin
        rw_req = req_a;
        rw_we  = wbs_a_we_i;
        rw_sel = wbs_a_sel_i;
        rw_dat = wbs_a_dat_i;
        rw_adr = wbs_a_adr_i;
        ro_req = req_b;
        ro_we  = wbs_b_we_i;
        ro_adr = wbs_b_adr_i;
        if (owner_q == OWN_B) begin
            rw_req = req_b;
            rw_we  = wbs_b_we_i;
            rw_sel = wbs_b_sel_i;
            rw_dat = wbs_b_dat_i;
            rw_adr = wbs_b_adr_i;
            ro_req = req_a;
            ro_we  = wbs_a_we_i;
            ro_adr = wbs_a_adr_i;
        end
    end

    assign ram_clk0   = wb_clk_i;
    assign ram_clk1   = wb_clk_i;
    // Selects are gated by reset so the macro stays idle while reset is held.
    assign ram_csb0   = ~(rw_req & wb_rst_n_i);
    assign ram_web0   = ~(rw_we & wb_rst_n_i);
    assign ram_wmask0 = rw_sel;
    assign ram_addr0  = rw_adr[2 +: RAM_ADR_W];
    assign ram_din0   = rw_dat;
    assign ram_csb1   = ~(ro_req & ~ro_we & wb_rst_n_i);
    assign ram_addr1  = ro_adr[2 +: RAM_ADR_W];

    assign wbs_a_ack_o = ack_a_q;
    assign wbs_b_ack_o = ack_b_q;

    // Write acks return zero: the macro leaves dout stale when web0 is low.
    assign wbs_a_dat_o = (ack_a_q && !wbs_a_we_i) ? ((owner_q == OWN_A) ? ram_dout0 : ram_dout1) : '0;
    assign wbs_b_dat_o = (ack_b_q && !wbs_b_we_i) ? ((owner_q == OWN_B) ? ram_dout0 : ram_dout1) : '0;

endmodule

// File: tb/tb_wb_openram_wrapper.sv
// Bench for wb_openram_wrapper: behavioural SRAM macro plus a word-array reference
// model of memory contents and port ownership.
module tb_wb_openram_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wpr;
    logic        a_stb, a_cyc, a_we, b_stb, b_cyc, b_we;
    logic [3:0]  a_sel, b_sel;
    logic [31:0] a_dat, b_dat;
    logic [9:0]  a_adr, b_adr;
    logic        a_ack, b_ack;
    logic [31:0] a_rdat, b_rdat;

    logic        ram_clk0, ram_clk1, ram_csb0, ram_csb1, ram_web0;
    logic [3:0]  ram_wmask0;
    logic [7:0]  ram_addr0, ram_addr1;
    logic [31:0] ram_din0, ram_dout0, ram_dout1;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          ref_owner;
    int          checks = 0;
    int          errors = 0;

    wb_openram_wrapper #(.ADR_W(10), .RAM_ADR_W(8), .DAT_W(32)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .writable_port_req(wpr),
        .wbs_a_stb_i(a_stb), .wbs_a_cyc_i(a_cyc), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
        .wbs_a_dat_i(a_dat), .wbs_a_adr_i(a_adr), .wbs_a_ack_o(a_ack), .wbs_a_dat_o(a_rdat),
        .wbs_b_stb_i(b_stb), .wbs_b_cyc_i(b_cyc), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
        .wbs_b_dat_i(b_dat), .wbs_b_adr_i(b_adr), .wbs_b_ack_o(b_ack), .wbs_b_dat_o(b_rdat),
        .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
        .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0),
        .ram_clk1(ram_clk1), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the hard macro: inputs captured on the rising edge.
    always @(posedge ram_clk0) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int i = 0; i < 4; i++)
                    if (ram_wmask0[i]) mem[ram_addr0][8*i +: 8] <= ram_din0[8*i +: 8];
            end else begin
                ram_dout0 <= mem[ram_addr0];
            end
        end
    end

    always @(posedge ram_clk1) begin
        if (!ram_csb1) ram_dout1 <= mem[ram_addr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic release_ports();
        a_stb = 0; a_cyc = 0; a_we = 0;
        b_stb = 0; b_cyc = 0; b_we = 0;
    endtask

    // One access on either/both ports, started at a falling edge; ends at a falling edge
    // one cycle after the ack, with both ports idle.
    task automatic xfer(input string tag,
                        input bit ae, input bit aw, input logic [9:0] aadr, input logic [3:0] asel,
                        input logic [31:0] adat,
                        input bit be, input bit bw, input logic [9:0] badr, input logic [3:0] bsel,
                        input logic [31:0] bdat,
                        output logic [31:0] obs_a, output logic [31:0] obs_b);
        logic [31:0] exp_a, exp_b;
        exp_a = (ae && !aw) ? ref_mem[aadr[9:2]] : 32'h0;
        exp_b = (be && !bw) ? ref_mem[badr[9:2]] : 32'h0;
        a_stb = ae; a_cyc = ae; a_we = aw; a_adr = aadr; a_sel = asel; a_dat = adat;
        b_stb = be; b_cyc = be; b_we = bw; b_adr = badr; b_sel = bsel; b_dat = bdat;
        @(posedge clk); @(negedge clk);
        check({tag, ".ack_a"}, {31'h0, a_ack}, {31'h0, ae});
        check({tag, ".ack_b"}, {31'h0, b_ack}, {31'h0, be});
        check({tag, ".dat_a"}, a_rdat, exp_a);
        check({tag, ".dat_b"}, b_rdat, exp_b);
        obs_a = a_rdat;
        obs_b = b_rdat;
        if (ae && aw && !ref_owner) ref_mem[aadr[9:2]] = merge(ref_mem[aadr[9:2]], adat, asel);
        if (be && bw &&  ref_owner) ref_mem[badr[9:2]] = merge(ref_mem[badr[9:2]], bdat, bsel);
        release_ports();
        @(posedge clk); @(negedge clk);
        check({tag, ".ack_a_drop"}, {31'h0, a_ack}, 32'h0);
        check({tag, ".ack_b_drop"}, {31'h0, b_ack}, 32'h0);
    endtask

    task automatic set_owner(input bit v);
        wpr = v;
        repeat (2) @(negedge clk);
        ref_owner = v;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          ae, aw, be, bw;
        logic [9:0]  aadr, badr;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_dout0 = 32'h0; ram_dout1 = 32'h0;
        rst_n = 0; wpr = 0; ref_owner = 0;
        a_adr = '0; a_sel = '0; a_dat = '0; b_adr = '0; b_sel = '0; b_dat = '0;
        release_ports();
        #2;
        check("rst.ack_a", {31'h0, a_ack}, 32'h0);
        check("rst.ack_b", {31'h0, b_ack}, 32'h0);
        check("rst.dat_a", a_rdat, 32'h0);
        check("rst.dat_b", b_rdat, 32'h0);
        check("rst.csb0", {31'h0, ram_csb0}, 32'h1);
        check("rst.csb1", {31'h0, ram_csb1}, 32'h1);
        check("rst.web0", {31'h0, ram_web0}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // A owns RW: write then cross-read on B.
        xfer("a_wr_010", 1, 1, 10'h010, 4'hF, 32'hDEADBEEF, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        xfer("b_rd_010", 0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h010, 4'h0, 32'h0, ra, rb);
        check("b_rd_010.const", rb, 32'hDEADBEEF);

        // Byte-lane write merge.
        xfer("a_wr_020", 1, 1, 10'h020, 4'hF, 32'h11223344, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        xfer("a_wr_020_b1", 1, 1, 10'h022, 4'h2, 32'hAABBCCDD, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        xfer("a_rd_020", 1, 0, 10'h023, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        check("a_rd_020.const", ra, 32'h1122CC44);

        // Write from the read-only port is acked but discarded.
        xfer("a_wr_030", 1, 1, 10'h030, 4'hF, 32'h0BADF00D, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        xfer("b_wr_030", 0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h030, 4'hF, 32'h00000055, ra, rb);
        xfer("a_rd_030", 1, 0, 10'h030, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        check("a_rd_030.const", ra, 32'h0BADF00D);

        // Hand RW to B while idle; top-of-range address.
        set_owner(1);
        xfer("b_wr_3fc", 0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h3FC, 4'hF, 32'hCAFEF00D, ra, rb);
        xfer("a_rd_3fc", 1, 0, 10'h3FF, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        check("a_rd_3fc.const", ra, 32'hCAFEF00D);

        // Ownership request toggled while A holds stb: B must keep RW until bus idle.
        a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 10'h3FC; wpr = 0;
        #1;
        check("hold.csb1_req1", {31'h0, ram_csb1}, 32'h0);
        check("hold.csb0_req1", {31'h0, ram_csb0}, 32'h1);
        @(posedge clk); @(negedge clk);
        check("hold.ack1", {31'h0, a_ack}, 32'h1);
        check("hold.dat1", a_rdat, 32'hCAFEF00D);
        @(posedge clk); @(negedge clk);
        check("hold.ack_gap", {31'h0, a_ack}, 32'h0);
        check("hold.csb1_req2", {31'h0, ram_csb1}, 32'h0);
        check("hold.csb0_req2", {31'h0, ram_csb0}, 32'h1);
        @(posedge clk); @(negedge clk);
        check("hold.ack2", {31'h0, a_ack}, 32'h1);
        release_ports();
        @(posedge clk); @(negedge clk);
        check("hold.ack_drop", {31'h0, a_ack}, 32'h0);
        @(negedge clk);
        ref_owner = 0;
        xfer("own_a_wr", 1, 1, 10'h040, 4'hF, 32'h12345678, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        xfer("own_b_rd", 0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h040, 4'h0, 32'h0, ra, rb);
        check("own_b_rd.const", rb, 32'h12345678);

        // Randomised concurrent traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            if ((n % 8) == 0) set_owner(bit'($urandom_range(0, 1)));
            ae = bit'($urandom_range(0, 1)); aw = bit'($urandom_range(0, 1));
            be = bit'($urandom_range(0, 1)); bw = bit'($urandom_range(0, 1));
            aadr = 10'($urandom); badr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) aadr = 10'h3FC | 10'($urandom_range(0, 3));
            if (ae && be && aadr[9:2] == badr[9:2] &&
                ((!ref_owner && aw && !bw) || (ref_owner && bw && !aw)))
                badr = badr ^ 10'h004;
            xfer("rand", ae, aw, aadr, 4'($urandom), $urandom,
                 be, bw, badr, 4'($urandom), $urandom, ra, rb);
        end

        // Reset asserted during an ack; stored data survives.
        set_owner(0);
        xfer("pre_rst_wr", 1, 1, 10'h010, 4'hF, 32'hFEEDFACE, 0, 0, 10'h0, 4'h0, 32'h0, ra, rb);
        a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 10'h010;
        @(posedge clk); @(negedge clk);
        check("mid_rst.ack_before", {31'h0, a_ack}, 32'h1);
        rst_n = 0;
        #1;
        check("mid_rst.ack_async", {31'h0, a_ack}, 32'h0);
        check("mid_rst.dat_async", a_rdat, 32'h0);
        check("mid_rst.csb0", {31'h0, ram_csb0}, 32'h1);
        release_ports();
        @(negedge clk);
        rst_n = 1;
        ref_owner = 0;
        @(negedge clk);
        xfer("post_rst_rd", 0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h010, 4'h0, 32'h0, ra, rb);
        check("post_rst_rd.const", rb, 32'hFEEDFACE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_openram_wrapper.md
Name: wb_openram_wrapper

Overview:
Dual-port Wishbone slave front-end for the OpenRAM macro sky130_sram_1kbyte_1rw1r_32x256_8 (256 x 32-bit words, one RW port and one R-only port).
Two Wishbone ports, A and B, share the RAM. writable_port_req selects which port is routed to RAM port 0 (RW); the other port is routed to RAM port 1 (read-only).
The block sits between two bus masters (e.g. CPU and peripheral DMA) and the hard SRAM macro.

Parameters:
ADR_W, 10, Wishbone byte-address width
RAM_ADR_W, 8, RAM word-address width (ADR_W-2)
DAT_W, 32, data width; SEL width is DAT_W/8

Ports:
wb_clk_i  in  1  single clock for both Wishbone ports and both RAM ports
wb_rst_n_i  in  1  reset, asynchronous, active-low
writable_port_req  in  1  0 = port A gets RW port, 1 = port B gets RW port
wbs_a_stb_i / wbs_b_stb_i  in  1  Wishbone strobe
wbs_a_cyc_i / wbs_b_cyc_i  in  1  Wishbone cycle
wbs_a_we_i / wbs_b_we_i  in  1  write enable
wbs_a_sel_i / wbs_b_sel_i  in  4  byte selects
wbs_a_dat_i / wbs_b_dat_i  in  32  write data
wbs_a_adr_i / wbs_b_adr_i  in  10  byte address
wbs_a_ack_o / wbs_b_ack_o  out  1  acknowledge
wbs_a_dat_o / wbs_b_dat_o  out  32  read data
ram_clk0, ram_clk1  out  1  RAM clocks, both driven by wb_clk_i
ram_csb0, ram_csb1  out  1  active-low chip selects
ram_web0  out  1  active-low write enable
ram_wmask0  out  4  byte write mask
ram_addr0, ram_addr1  out  8  word addresses
ram_din0  out  32  write data
ram_dout0, ram_dout1  in  32  read data from RAM

Behaviour:
- Reset (wb_rst_n_i low, async): both ack outputs 0; both dat_o 0; port-select register = 0 (A writable); ram_csb0 = ram_csb1 = 1; ram_web0 = 1.
- Port-select register:
  - Loads writable_port_req on a rising edge only when neither port has a request (stb&cyc) or an ack in flight.
  - Otherwise it holds its value, so a port is never swapped mid-transaction.
- Request on a port: req = stb & cyc & ~ack.
- RW routing (port at RAM port 0):
  - ram_csb0 = ~req; ram_web0 = ~we; ram_wmask0 = sel (all 4 bits 1 for reads is acceptable).
  - ram_addr0 = adr[9:2]; ram_din0 = dat_i. All combinational from the selected port.
- R routing (other port at RAM port 1):
  - ram_csb1 = ~(req & ~we); ram_addr1 = adr[9:2].
  - Writes on this port: RAM port 1 not selected, data discarded, still acknowledged.
- Address bits [1:0] ignored. Address wraps within 256 words.
- Timing:
  - RAM captures inputs on the rising edge where req is high.
  - Ack is a register set on that same edge, so ack is high for exactly one cycle, in the following cycle.
  - Latency is 1 cycle for both reads and writes.
  - ack is cleared on the next edge even if stb stays high. Because req includes ~ack, back-to-back requests alternate request and ack cycles (max one access per 2 cycles per port).
- Read data: dat_o = RAM dout of the port's assigned RAM port while ack is high, else 0. Writes return 0 on dat_o.
- Both ports operate independently in the same cycle.
- Same-address collision (port 0 write, port 1 read, same edge): the read returns undefined data. No arbitration is performed; masters must avoid this case.
- Reset asserted mid-transaction: ack is cleared immediately and the transaction is lost.

Test Plan:
- Reset, writable_port_req=0; A writes 0xDEADBEEF to adr 0x010 with sel=0xF -> wbs_a_ack_o high one cycle later, for one cycle. B reads adr 0x010 -> wbs_b_dat_o=0xDEADBEEF during ack.
- A writes 0x11223344 to adr 0x020, then writes 0xAABBCCDD with sel=0x2 -> A read of 0x020 returns 0x1122CC44.
- writable_port_req=0; B writes 0x55 to 0x030 -> ack asserted, RAM unchanged (A read of 0x030 returns the old value).
- Set writable_port_req=1 while both ports idle; B writes 0xCAFEF00D to 0x3FC -> A read returns 0xCAFEF00D.
- Toggle writable_port_req while A holds stb -> ownership does not change until A's ack completes and the bus is idle.
- Assert wb_rst_n_i low while an ack is high -> ack drops immediately without waiting for a clock edge. After release, a fresh read of a previously written address returns the stored data.
